// File: rtl/exe_div_unit_pkg.sv
// Shared definitions for the EXE-stage iterative divider: state encodings
// and default sizing.
package exe_div_unit_pkg;

   // Number of restoring iterations for a full-width divide.
   localparam int DIV_ITER  = 32;
   // Default iteration counter width (>= clog2(DIV_ITER)+1).
   localparam int DIV_CNT_W = 6;

   // Divider sequencing states.
   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_CALC = 2'b01,
      DIV_FIX  = 2'b10,
      DIV_DONE = 2'b11
   } div_state_t;

endpackage

// File: rtl/exe_div_unit_div_step.sv
// One radix-2 restoring division step on magnitudes.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module exe_div_unit_div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_rem_in,
   input  logic              i_dq_msb,
   input  logic [DATA_W-1:0] i_divisor,
   output logic [DATA_W-1:0] o_rem_out,
   output logic              o_q_bit
);

   // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
   logic [DATA_W:0]   w_shift;
   logic [DATA_W-1:0] w_diff_lo;
   logic              w_ge;

   assign w_shift   = {i_rem_in, i_dq_msb};
   // When the divisor fits, the difference is below the divisor, so the low
   // DATA_W bits of the subtraction are the whole result.
   assign w_diff_lo = w_shift[DATA_W-1:0] - i_divisor;
   assign w_ge      = (w_shift >= {1'b0, i_divisor});

   // Select restored or reduced remainder and emit the quotient bit.
   always_comb begin
      o_rem_out = w_shift[DATA_W-1:0];
      o_q_bit   = 1'b0;
      if (w_ge) begin
         o_rem_out = w_diff_lo;
         o_q_bit   = 1'b1;
      end else begin
         o_rem_out = w_shift[DATA_W-1:0];
         o_q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/exe_div_unit.sv
// Iterative MIPS DIV/DIVU engine for the EXE stage.
// Divides operand magnitudes with a restoring algorithm (one bit per cycle),
// fixes up signs in a final cycle, then holds the result until EXE advances.
// Quotient goes to LO, remainder to HI.
module exe_div_unit
   import exe_div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_ITER,
   parameter int CNT_W  = DIV_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              div_start,
   input  logic              div_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              res_ack,
   output logic              div_busy,
   output logic              div_done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam logic [CNT_W-1:0]  LP_CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  LP_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] LP_ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] LP_ZERO     = {DATA_W{1'b0}};
   localparam logic [DATA_W-1:0] LP_ONES     = {DATA_W{1'b1}};

   // Two's complement negate, modulo 2^DATA_W.
   function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
      f_neg = ~v + LP_ONE;
   endfunction

   div_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_dq;        // dividend magnitude shifting out, quotient shifting in
   logic [DATA_W-1:0] r_rem;       // partial remainder
   logic [DATA_W-1:0] r_dvs;       // divisor magnitude
   logic [DATA_W-1:0] r_raw_dvd;   // unmodified dividend, returned on divide-by-zero
   logic              r_sign_q;
   logic              r_sign_r;
   logic              r_div_zero;
   logic [DATA_W-1:0] r_quotient;
   logic [DATA_W-1:0] r_remainder;
   logic              r_div_done;

   logic              w_a_neg;
   logic              w_b_neg;
   logic [DATA_W-1:0] w_a_abs;
   logic [DATA_W-1:0] w_b_abs;
   logic [DATA_W-1:0] w_rem_next;
   logic              w_q_bit;
   logic [DATA_W-1:0] w_q_fix;
   logic [DATA_W-1:0] w_r_fix;

   // Operands are treated as negative only for DIV.
   assign w_a_neg = div_signed & dividend[DATA_W-1];
   assign w_b_neg = div_signed & divisor[DATA_W-1];
   assign w_a_abs = w_a_neg ? f_neg(dividend) : dividend;
   assign w_b_abs = w_b_neg ? f_neg(divisor) : divisor;

   exe_div_unit_div_step #(
      .DATA_W (DATA_W)
   ) u_div_step (
      .i_rem_in  (r_rem),
      .i_dq_msb  (r_dq[DATA_W-1]),
      .i_divisor (r_dvs),
      .o_rem_out (w_rem_next),
      .o_q_bit   (w_q_bit)
   );

   // Sign fixup of the magnitude result; divide-by-zero bypasses it.
   always_comb begin
      w_q_fix = r_dq;
      w_r_fix = r_rem;
      if (r_div_zero) begin
         w_q_fix = LP_ONES;
         w_r_fix = r_raw_dvd;
      end else begin
         if (r_sign_q) begin
            w_q_fix = f_neg(r_dq);
         end else begin
            w_q_fix = r_dq;
         end
         if (r_sign_r) begin
            w_r_fix = f_neg(r_rem);
         end else begin
            w_r_fix = r_rem;
         end
      end
   end

   // Divider FSM, iteration datapath and registered results.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= DIV_IDLE;
         r_cnt       <= {CNT_W{1'b0}};
         r_dq        <= LP_ZERO;
         r_rem       <= LP_ZERO;
         r_dvs       <= LP_ZERO;
         r_raw_dvd   <= LP_ZERO;
         r_sign_q    <= 1'b0;
         r_sign_r    <= 1'b0;
         r_div_zero  <= 1'b0;
         r_quotient  <= LP_ZERO;
         r_remainder <= LP_ZERO;
         r_div_done  <= 1'b0;
      end else if (flush) begin
         // A kill abandons any divide in flight; the last result stays visible.
         r_state    <= DIV_IDLE;
         r_div_done <= 1'b0;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               if (div_start) begin
                  r_dq       <= w_a_abs;
                  r_dvs      <= w_b_abs;
                  r_raw_dvd  <= dividend;
                  r_rem      <= LP_ZERO;
                  r_sign_q   <= w_a_neg ^ w_b_neg;
                  r_sign_r   <= w_a_neg;
                  r_div_zero <= (divisor == LP_ZERO);
                  r_cnt      <= {CNT_W{1'b0}};
                  r_state    <= DIV_CALC;
               end else begin
                  r_state <= DIV_IDLE;
               end
            end
            DIV_CALC: begin
               r_rem <= w_rem_next;
               r_dq  <= {r_dq[DATA_W-2:0], w_q_bit};
               if (r_cnt == LP_CNT_LAST) begin
                  r_state <= DIV_FIX;
               end else begin
                  r_cnt <= r_cnt + LP_CNT_ONE;
               end
            end
            DIV_FIX: begin
               r_quotient  <= w_q_fix;
               r_remainder <= w_r_fix;
               r_div_done  <= 1'b1;
               r_state     <= DIV_DONE;
            end
            DIV_DONE: begin
               if (res_ack) begin
                  r_div_done <= 1'b0;
                  r_state    <= DIV_IDLE;
               end else begin
                  r_state <= DIV_DONE;
               end
            end
            default: begin
               r_div_done <= 1'b0;
               r_state    <= DIV_IDLE;
            end
         endcase
      end
   end

   // Stall EXE while a divide is being accepted or computed; released in DONE.
   assign div_busy = ~flush & (((r_state == DIV_IDLE) & div_start) |
                               (r_state == DIV_CALC) |
                               (r_state == DIV_FIX));

   assign div_done  = r_div_done;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;

endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: directed vector table, multi-cycle
// corner sequences (hold, flush, reset, ignored start/ack) and random ops
// compared against a behavioural divide model.
module tb_exe_div_unit;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        div_start;
   logic        div_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        res_ack;
   logic        div_busy;
   logic        div_done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] last_q = 32'd0;
   logic [31:0] last_r = 32'd0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   vec_t vecs[12];

   exe_div_unit dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .div_start  (div_start),
      .div_signed (div_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .res_ack    (res_ack),
      .div_busy   (div_busy),
      .div_done   (div_done),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // One complete divide: start, wait for done, optional hold, then ack.
   // Leaves res_ack high so the next op can start back-to-back.
   task automatic do_op(input string nm, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input int hold, input bit noise, input bit chk_timing);
      int busy_n;
      int done_at;
      @(posedge clk); #1;
      res_ack = 1'b0; div_start = 1'b1; div_signed = sgn; dividend = a; divisor = b;
      @(negedge clk);
      if (chk_timing) check({nm, "_done_low_at_start"}, {31'd0, div_done}, 32'd0);
      busy_n  = div_busy ? 1 : 0;
      done_at = -1;
      for (int k = 1; k <= 40 && done_at < 0; k++) begin
         @(posedge clk); #1;
         if (noise && k >= 5 && k <= 7) begin
            div_start = 1'b1; div_signed = ~sgn; dividend = 32'h1234_5678; divisor = 32'd3;
            res_ack = 1'b1;
         end else begin
            div_start = 1'b0; res_ack = 1'b0;
         end
         @(negedge clk);
         if (div_busy) busy_n++;
         if (div_done) done_at = k;
      end
      if (chk_timing) begin
         check({nm, "_latency"}, 32'(done_at), 32'd34);
         check({nm, "_busy_cycles"}, 32'(busy_n), 32'd34);
      end
      check({nm, "_q"}, quotient, eq);
      check({nm, "_r"}, remainder, er);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check($sformatf("%s_hold%0d_done", nm, h), {31'd0, div_done}, 32'd1);
         check($sformatf("%s_hold%0d_q", nm, h), quotient, eq);
         check($sformatf("%s_hold%0d_r", nm, h), remainder, er);
      end
      @(posedge clk); #1;
      res_ack = 1'b1;
      last_q = eq;
      last_r = er;
   endtask

   initial begin
      logic [31:0] ra, rb, mq, mr;
      logic        rs;
      int          dn;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
      vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
      vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
      vecs[5]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
      vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
      vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF};
      vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
      vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
      vecs[10] = '{1'b1, 32'd0,          32'd5,          32'd0,          32'd0};
      vecs[11] = '{1'b0, 32'd3,          32'd7,          32'd0,          32'd3};

      reset = 1'b0; flush = 1'b0; div_start = 1'b0; div_signed = 1'b0;
      dividend = 32'd0; divisor = 32'd0; res_ack = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_q", quotient, 32'd0);
      check("rst_r", remainder, 32'd0);
      check("rst_done", {31'd0, div_done}, 32'd0);
      check("rst_busy", {31'd0, div_busy}, 32'd0);

      // Directed vector table, back-to-back.
      for (int i = 0; i < 12; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
               vecs[i].q, vecs[i].r, 0, 1'b0, 1'b1);
      end

      // DONE held 5 cycles, then ack with an immediate back-to-back start.
      do_op("hold", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 5, 1'b0, 1'b1);
      do_op("b2b", 1'b1, 32'hFFFF_FC18, 32'd9, 32'hFFFF_FF91, 32'hFFFF_FFFF, 0, 1'b0, 1'b1);

      // Start and ack while busy are ignored.
      do_op("noise", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 1'b1, 1'b1);

      // Flush in CALC cycle 10.
      @(posedge clk); #1;
      res_ack = 1'b0; div_start = 1'b1; div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1 div_start = 1'b0;
      end
      @(posedge clk); #1 flush = 1'b1;
      @(negedge clk);
      check("flush_busy_forced_low", {31'd0, div_busy}, 32'd0);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush_idle_busy", {31'd0, div_busy}, 32'd0);
      dn = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (div_done) dn++;
      end
      check("flush_no_done", 32'(dn), 32'd0);
      check("flush_q_kept", quotient, last_q);
      check("flush_r_kept", remainder, last_r);
      do_op("after_flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 1'b0, 1'b1);

      // Start and flush in the same cycle: must stay idle.
      @(posedge clk); #1;
      res_ack = 1'b0; div_start = 1'b1; flush = 1'b1; dividend = 32'd50; divisor = 32'd5;
      @(negedge clk);
      check("startflush_busy", {31'd0, div_busy}, 32'd0);
      @(posedge clk); #1 div_start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("startflush_idle", {31'd0, div_busy}, 32'd0);
      dn = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (div_done) dn++;
      end
      check("startflush_no_done", 32'(dn), 32'd0);

      // Reset in the middle of CALC.
      @(posedge clk); #1;
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'hFFFF; divisor = 32'd7;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1 div_start = 1'b0;
      end
      reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("midrst_q", quotient, 32'd0);
      check("midrst_r", remainder, 32'd0);
      check("midrst_done", {31'd0, div_done}, 32'd0);
      check("midrst_busy", {31'd0, div_busy}, 32'd0);
      do_op("after_rst", 1'b0, 32'hFFFF, 32'd7, 32'd9362, 32'd1, 0, 1'b0, 1'b1);

      // Random signed/unsigned against the behavioural model.
      for (int i = 0; i < 100; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) rb = 32'hFFFF_FFFF;
         if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
         model(rs, ra, rb, mq, mr);
         do_op($sformatf("rnd%0d", i), rs, ra, rb, mq, mr, 0, 1'b0, 1'b0);
      end

      @(posedge clk); #1 res_ack = 1'b0;
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
